// File: rtl/nor_logic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nor_logic_pkg
//  Purpose  : Shared opcode encodings, FSM state encoding and sweep limit
//             for the NOR-based logic unit.
//  Contents : OP_AND..OP_NOT, OP_RSVD, LAST_SWEEP_OP, state_t
//  Revision : 1.0  initial release
// ============================================================================
package nor_logic_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_RSVD = 3'd7;

   // A sweep walks opcodes 0..LAST_SWEEP_OP; the reserved opcode is never swept.
   localparam logic [2:0] LAST_SWEEP_OP = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_SWEEP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/nor_gate_slice.sv
`default_nettype none
// ============================================================================
//  Module   : nor_gate_slice
//  Purpose  : Combinational slice producing all seven basic bitwise logic
//             functions of two WIDTH-bit operands from NOR expressions only.
//  Ports    : i_a, i_b          operands
//             o_and .. o_not    function outputs (o_not = NOT i_a)
//  Revision : 1.0  initial release
// ============================================================================
module nor_gate_slice #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_and,
   output logic [WIDTH-1:0] o_or,
   output logic [WIDTH-1:0] o_nand,
   output logic [WIDTH-1:0] o_nor,
   output logic [WIDTH-1:0] o_xor,
   output logic [WIDTH-1:0] o_xnor,
   output logic [WIDTH-1:0] o_not
);

   logic [WIDTH-1:0] w_na;
   logic [WIDTH-1:0] w_nb;
   logic [WIDTH-1:0] w_nor;
   logic [WIDTH-1:0] w_and;
   logic [WIDTH-1:0] w_a_nb;
   logic [WIDTH-1:0] w_na_b;
   logic [WIDTH-1:0] w_xnor;
   logic [WIDTH-1:0] w_xor;

   // Inversion is a NOR with both inputs tied together.
   assign w_na   = ~(i_a | i_a);
   assign w_nb   = ~(i_b | i_b);
   assign w_nor  = ~(i_a | i_b);
   assign w_and  = ~(w_na | w_nb);
   // Cross terms: a & ~b = NOR(~a, b) and ~a & b = NOR(a, ~b).
   assign w_a_nb = ~(w_na | i_b);
   assign w_na_b = ~(i_a | w_nb);
   // NOR of the cross terms is XNOR; inverting it gives XOR (their OR).
   assign w_xnor = ~(w_a_nb | w_na_b);
   assign w_xor  = ~(w_xnor | w_xnor);

   assign o_not  = w_na;
   assign o_nor  = w_nor;
   assign o_or   = ~(w_nor | w_nor);
   assign o_and  = w_and;
   assign o_nand = ~(w_and | w_and);
   assign o_xor  = w_xor;
   assign o_xnor = w_xnor;

endmodule
`default_nettype wire

// File: rtl/nor_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module   : nor_logic_unit
//  Purpose  : Sequential WIDTH-bit logic unit. Accepts an operand pair via
//             valid/ready, then presents either one result (HOLD) or all
//             seven function results in opcode order (SWEEP).
//  Ports    : clk, rst                       clock, sync active-high reset
//             in_valid/in_ready, a, b, op, sweep   operand handshake
//             out_valid/out_ready, result, out_op, out_last  result handshake
//             ops_done                        completed output handshakes
//  Revision : 1.0  initial release
// ============================================================================
module nor_logic_unit
   import nor_logic_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             sweep,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       out_op,
   output logic             out_last,
   output logic [15:0]      ops_done
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   // Latched opcode in HOLD, sweep position counter in SWEEP.
   logic [2:0]       r_op;
   logic [15:0]      r_ops_done;

   logic             w_valid;
   logic             w_last;
   logic             w_out_fire;
   logic             w_in_ready;
   logic             w_in_fire;
   logic [WIDTH-1:0] w_mux;

   logic [WIDTH-1:0] w_and, w_or, w_nand, w_nor, w_xor, w_xnor, w_not;

   nor_gate_slice #(.WIDTH(WIDTH)) u_slice (
      .i_a    (r_a),
      .i_b    (r_b),
      .o_and  (w_and),
      .o_or   (w_or),
      .o_nand (w_nand),
      .o_nor  (w_nor),
      .o_xor  (w_xor),
      .o_xnor (w_xnor),
      .o_not  (w_not)
   );

   assign w_valid    = (r_state != ST_IDLE);
   assign w_last     = (r_state == ST_HOLD) ||
                       ((r_state == ST_SWEEP) && (r_op == LAST_SWEEP_OP));
   assign w_out_fire = w_valid && out_ready;
   // Accepting while the final result leaves keeps transactions back to back.
   assign w_in_ready = !rst && ((r_state == ST_IDLE) || (w_out_fire && w_last));
   assign w_in_fire  = in_valid && w_in_ready;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_in_fire) begin
         w_state_nxt = sweep ? ST_SWEEP : ST_HOLD;
      end else if (w_out_fire && w_last) begin
         w_state_nxt = ST_IDLE;
      end
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= 3'd0;
         r_ops_done <= 16'd0;
      end else begin
         if (w_in_fire) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= sweep ? OP_AND : op;
         end else if (w_out_fire && (r_state == ST_SWEEP) && !w_last) begin
            r_op <= r_op + 3'd1;
         end
         if (w_out_fire) begin
            r_ops_done <= r_ops_done + 16'd1;
         end
      end
   end

   always_comb begin
      w_mux = '0;
      case (r_op)
         OP_AND:  w_mux = w_and;
         OP_OR:   w_mux = w_or;
         OP_NAND: w_mux = w_nand;
         OP_NOR:  w_mux = w_nor;
         OP_XOR:  w_mux = w_xor;
         OP_XNOR: w_mux = w_xnor;
         OP_NOT:  w_mux = w_not;
         OP_RSVD: w_mux = '0;
         default: w_mux = '0;
      endcase
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_valid;
   assign result    = w_valid ? w_mux : '0;
   assign out_op    = w_valid ? r_op  : 3'd0;
   assign out_last  = w_valid && w_last;
   assign ops_done  = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_nor_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nor_logic_unit
//  Purpose  : Self-checking bench for nor_logic_unit (WIDTH = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_nor_logic_unit;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic [2:0]       op = 3'd0;
   logic             sweep = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic [2:0]       out_op;
   logic             out_last;
   logic [15:0]      ops_done;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_done = 16'd0;
   logic [7:0]  fixed_tbl [7] = '{8'h24, 8'hBD, 8'hDB, 8'h42, 8'h99, 8'h66, 8'h5A};

   always #5 clk = ~clk;

   nor_logic_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .sweep     (sweep),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_op    (out_op),
      .out_last  (out_last),
      .ops_done  (ops_done)
   );

   // Behavioural reference: plain boolean operators, no NOR decomposition.
   function automatic logic [WIDTH-1:0] ref_fn(input logic [2:0] f,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
      case (f)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return ~(x & y);
         3'd3:    return ~(x | y);
         3'd4:    return x ^ y;
         3'd5:    return ~(x ^ y);
         3'd6:    return ~x;
         default: return '0;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_tests++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 00", result); end
      n_tests++; if (ops_done !== 16'd0) begin n_fail++; $display("FAIL reset_ops_done got %h want 0000", ops_done); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
      exp_done = 16'd0;
   endtask

   // One single-mode transaction per opcode, idle cycle between them.
   task automatic test_single(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                              input bit use_tbl);
      logic [WIDTH-1:0] exp_r;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         exp_r = ref_fn(3'(k), va, vb);
         if (use_tbl && k < 7) exp_r = fixed_tbl[k];
         in_valid = 1'b1; a = va; b = vb; op = 3'(k); sweep = 1'b0; out_ready = 1'b1;
         #1;
         n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready op=%0d got %b want 1", k, in_ready); end
         @(negedge clk);
         in_valid = 1'b0; a = ~va; b = ~vb;
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid op=%0d got %b want 1", k, out_valid); end
         n_tests++; if (result !== exp_r) begin n_fail++; $display("FAIL single_result op=%0d got %h want %h", k, result, exp_r); end
         n_tests++; if (out_op !== 3'(k)) begin n_fail++; $display("FAIL single_out_op got %0d want %0d", out_op, k); end
         n_tests++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL single_last op=%0d got %b want 1", k, out_last); end
         exp_done = exp_done + 16'd1;
         @(negedge clk);
      end
      n_tests++; if (out_valid !== 1'b0 || result !== '0 || out_op !== 3'd0 || out_last !== 1'b0) begin
         n_fail++; $display("FAIL single_idle_outputs got v=%b r=%h op=%0d l=%b want all 0", out_valid, result, out_op, out_last);
      end
      n_tests++; if (ops_done !== exp_done) begin n_fail++; $display("FAIL single_ops_done got %h want %h", ops_done, exp_done); end
   endtask

   task automatic test_sweep(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
      logic [WIDTH-1:0] exp_r;
      @(negedge clk);
      in_valid = 1'b1; a = va; b = vb; op = 3'($urandom_range(0, 7)); sweep = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; sweep = 1'b0;
      for (int k = 0; k < 7; k++) begin
         exp_r = ref_fn(3'(k), va, vb);
         n_tests++; if (out_valid !== 1'b1 || result !== exp_r) begin
            n_fail++; $display("FAIL sweep_result step=%0d got v=%b r=%h want v=1 r=%h", k, out_valid, result, exp_r);
         end
         n_tests++; if (out_op !== 3'(k)) begin n_fail++; $display("FAIL sweep_out_op got %0d want %0d", out_op, k); end
         n_tests++; if (out_last !== (k == 6)) begin n_fail++; $display("FAIL sweep_last step=%0d got %b want %b", k, out_last, (k == 6)); end
         exp_done = exp_done + 16'd1;
         @(negedge clk);
      end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_end_valid got %b want 0", out_valid); end
      n_tests++; if (ops_done !== exp_done) begin n_fail++; $display("FAIL sweep_ops_done got %h want %h", ops_done, exp_done); end
   endtask

   // Stall at op 3 for 5 cycles while offering new operands that must be ignored.
   task automatic test_backpressure();
      @(negedge clk);
      in_valid = 1'b1; a = 8'hA5; b = 8'h3C; sweep = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; sweep = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k == 3) begin
            for (int s = 0; s < 5; s++) begin
               out_ready = 1'b0; in_valid = 1'b1; sweep = 1'(s & 1);
               a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
               #1;
               n_tests++; if (result !== 8'h42 || out_op !== 3'd3 || out_last !== 1'b0) begin
                  n_fail++; $display("FAIL bp_stall cyc=%0d got r=%h op=%0d l=%b want r=42 op=3 l=0", s, result, out_op, out_last);
               end
               n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got %b want 0", s, in_ready); end
               @(negedge clk);
            end
            in_valid = 1'b0; sweep = 1'b0; out_ready = 1'b1;
         end
         n_tests++; if (result !== fixed_tbl[k] || out_op !== 3'(k)) begin
            n_fail++; $display("FAIL bp_resume step=%0d got r=%h op=%0d want r=%h op=%0d", k, result, out_op, fixed_tbl[k], k);
         end
         exp_done = exp_done + 16'd1;
         @(negedge clk);
      end
      n_tests++; if (ops_done !== exp_done || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_end got done=%h v=%b want done=%h v=0", ops_done, out_valid, exp_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] va [4];
      logic [WIDTH-1:0] vb [4];
      logic [2:0]       vo [4];
      logic [WIDTH-1:0] exp_r;
      for (int i = 0; i < 4; i++) begin
         va[i] = 8'($urandom); vb[i] = 8'($urandom); vo[i] = 3'($urandom_range(0, 7));
      end
      vo[1] = 3'd7;
      @(negedge clk);
      out_ready = 1'b1; sweep = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            exp_r = ref_fn(vo[i-1], va[i-1], vb[i-1]);
            n_tests++; if (out_valid !== 1'b1 || result !== exp_r || out_op !== vo[i-1] || out_last !== 1'b1) begin
               n_fail++; $display("FAIL b2b_result idx=%0d got v=%b r=%h op=%0d l=%b want v=1 r=%h op=%0d l=1",
                                  i - 1, out_valid, result, out_op, out_last, exp_r, vo[i-1]);
            end
            exp_done = exp_done + 16'd1;
         end
         if (i < 4) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; op = vo[i];
            #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready idx=%0d got %b want 1", i, in_ready); end
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      n_tests++; if (out_valid !== 1'b0 || ops_done !== exp_done) begin
         n_fail++; $display("FAIL b2b_end got v=%b done=%h want v=0 done=%h", out_valid, ops_done, exp_done);
      end
   endtask

   task automatic test_reset_mid_sweep();
      @(negedge clk);
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); sweep = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; sweep = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (out_op !== 3'd3 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL rms_pre got op=%0d v=%b want op=3 v=1", out_op, out_valid);
      end
      rst = 1'b1;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0 || result !== '0 || out_op !== 3'd0 || out_last !== 1'b0) begin
         n_fail++; $display("FAIL rms_outputs got v=%b r=%h op=%0d l=%b want all 0", out_valid, result, out_op, out_last);
      end
      n_tests++; if (ops_done !== 16'd0 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL rms_done_ready got done=%h rdy=%b want 0000 0", ops_done, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rms_release got rdy=%b v=%b want 1 0", in_ready, out_valid);
      end
      exp_done = 16'd0;
   endtask

   // Continuous single ops: one output fire per cycle up to 0xFFFF, then one more.
   task automatic test_wrap();
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'd0; sweep = 1'b0; out_ready = 1'b1;
      repeat (65535) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      exp_done = exp_done + 16'd65535;
      n_tests++; if (ops_done !== exp_done) begin n_fail++; $display("FAIL wrap_preload got %h want %h", ops_done, exp_done); end
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      exp_done = exp_done + 16'd1;
      n_tests++; if (ops_done !== exp_done) begin n_fail++; $display("FAIL wrap_rollover got %h want %h", ops_done, exp_done); end
   endtask

   initial begin
      test_reset();
      test_single(8'hA5, 8'h3C, 1'b1);
      test_single(8'($urandom), 8'($urandom), 1'b0);
      test_sweep(8'hA5, 8'h3C);
      test_sweep(8'($urandom), 8'($urandom));
      test_backpressure();
      test_back_to_back();
      test_back_to_back();
      test_reset_mid_sweep();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nor_logic_unit.md
# nor_logic_unit

Parametrised, sequential successor to the team's single-bit NOR-only gate set. It computes any of the seven basic logic functions (AND, OR, NAND, NOR, XOR, XNOR, NOT) bitwise on WIDTH-bit operands, and every function is built from NOR primitives only. Operands enter through a valid/ready handshake. Results leave through a registered valid/ready output. A sweep mode emits all seven results for one operand pair on consecutive handshakes. The block sits between lab stimulus logic (switches or a test sequencer) and display or checker logic.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored by NOT)
- op  in  3  opcode: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(a), 7 reserved
- sweep  in  1  sampled with operands; 1 = emit opcodes 0..6 in order
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  function of latched a/b under out_op
- out_op  out  3  opcode of the current result
- out_last  out  1  final result of the current transaction
- ops_done  out  16  count of completed output handshakes

## Operation
- FSM states: IDLE, HOLD (single result), SWEEP.
- Input fire occurs when in_valid & in_ready. On input fire, a, b and sweep are latched.
  - sweep=0: op is latched and the state goes to HOLD.
  - sweep=1: the op counter is set to 0 and the state goes to SWEEP. The op input is ignored.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last), and is forced to 0 while rst=1. This allows back-to-back transactions.
- HOLD behaviour:
  - out_valid=1, out_last=1, out_op = latched op.
  - On output fire, the state goes to IDLE, or reloads if a same-cycle input fire occurs.
- SWEEP behaviour:
  - out_valid=1 and out_op = counter.
  - Each output fire increments the counter.
  - out_last=1 when counter==6. Output fire at 6 returns the state to IDLE, or reloads.
  - The counter never reaches 7.
- Opcode 7 (reserved) produces result = 0 and is handled otherwise like any single op.
- result, out_op and out_last are 0 whenever out_valid=0.
- While out_valid & !out_ready, result, out_op and out_last hold stable.
- in_valid while in_ready=0 is ignored. No data is latched.
- ops_done increments on every output fire and wraps 0xFFFF→0x0000.
- Reset, including mid-sweep: state IDLE, out_valid 0, result/out_op/out_last 0, ops_done 0, latched operands 0. Any in-flight sweep is discarded.

## Timing
- Latency: input fire in cycle N gives out_valid=1 in cycle N+1.
- Single-mode throughput: one result per cycle when in_valid and out_ready are held high.
- Sweep: 7 output fires minimum, on cycles N+1..N+7 with out_ready=1. A new input can fire on cycle N+7.
- No combinational path from a, b, op or sweep to any output. in_ready depends combinationally on out_ready.
- Simultaneous output fire with out_last and input fire: the new operands are latched and out_valid stays 1. The next cycle shows the new transaction.

## Structure
- Package nor_logic_pkg holds:
  - opcode localparams OP_AND..OP_NOT and OP_RSVD;
  - FSM state encoding;
  - LAST_SWEEP_OP = 6.
- Sub-module nor_gate_slice (parameter WIDTH) is combinational. It produces all seven WIDTH-bit functions from a and b using only bitwise NOR expressions:
  - NOT = x NOR x;
  - OR = NOT of NOR;
  - AND = NOR of inverted inputs;
  - NAND = inverted AND;
  - XOR = OR of the two cross terms;
  - XNOR = inverted XOR.
- The top level holds the FSM, operand registers, op counter, ops_done counter and an output mux indexed by out_op.

## Test plan
- Reset with rst=1 for 2 cycles, mid-sweep after 3 results → next cycle out_valid=0, result=0, ops_done=0, in_ready=1 after rst falls.
- WIDTH=8, single mode, a=0xA5, b=0x3C, each op 0..6, out_ready=1 → results 0x24, 0xBD, 0xDB, 0x42, 0x99, 0x66, 0x5A, each one cycle after its input fire, with out_last=1.
- Sweep mode, a=0xA5, b=0x3C, out_ready=1 → 7 consecutive results in the order above, out_op 0..6, out_last only on the 7th, and ops_done advances by 7.
- Back-pressure: out_ready=0 for 5 cycles mid-sweep at op 3 → result=0x42 and out_op=3 stable, in_ready=0, new in_valid ignored. Releasing out_ready resumes at op 3.
- Back-to-back single ops with in_valid=1 and out_ready=1 for 4 cycles → 4 results on 4 consecutive cycles, no bubble. op=7 in the stream → result=0x00.
- ops_done preloaded via 65,535 fires, then one more fire → reads 0x0000.
